// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl
//   Multiply/divide sequencer for the shared multi-cycle HI/LO resource.
//   Owns HI/LO, launches mult/multu/div/divu from the EX stage, holds the
//   result in pending registers while the busy counter runs, and commits to
//   HI/LO when the counter expires. Also produces the decode-stage stall.
//
// Ports
//   clk         pipeline clock, rising edge
//   rst_n       synchronous active-low reset
//   hiloOpE     EX op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo,
//               7 reserved (none)
//   hiloWriteE  EX move-to: 01 mthi, 10 mtlo, others none
//   rsE, rtE    forwarded operands
//   mdUseD      ID-stage instruction touches HI/LO
//   start       op 1..4 accepted this cycle (combinational)
//   busy        unit computing (registered)
//   stallD      mdUseD && (start || busy)
//   mdOutE      HI for mfhi, LO for mflo, else 0
//   hi, lo      committed HI/LO registers
//
// Handshake: an op is accepted (start) only when the unit is idle; any op or
// move-to that reaches EX while busy is dropped. stallD keeps later HI/LO
// instructions in ID until the unit is idle again.
// -----------------------------------------------------------------------------
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  hiloOpE,
    input  logic [1:0]  hiloWriteE,
    input  logic [31:0] rsE,
    input  logic [31:0] rtE,
    input  logic        mdUseD,
    output logic        start,
    output logic        busy,
    output logic        stallD,
    output logic [31:0] mdOutE,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          commit;
    logic [31:0]   pend_hi, pend_lo;
    logic [31:0]   res_hi, res_lo;

    logic          is_mul, is_div;

    // Arithmetic intermediates
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   mag_rs, mag_rt, mag_rt_safe, rt_safe;
    logic [31:0]   q_mag, r_mag, q_u, r_u, q_s, r_s;

    assign is_mul = (hiloOpE == 3'd1) || (hiloOpE == 3'd2);
    assign is_div = (hiloOpE == 3'd3) || (hiloOpE == 3'd4);
    assign start  = (is_mul || is_div) && (state == S_IDLE);
    assign busy   = (state == S_BUSY);
    assign stallD = mdUseD && (start || busy);

    always_comb begin
        mdOutE = 32'd0;
        case (hiloOpE)
            3'd5:    mdOutE = hi;
            3'd6:    mdOutE = lo;
            default: mdOutE = 32'd0;
        endcase
    end

    // Full result computed in the launch cycle; it waits in pend_* until the
    // counter expires so HI/LO reflect the architectural latency.
    always_comb begin
        // Sign-extended operands: the low 64 bits of the product are the
        // signed 64-bit product.
        prod_s      = {{32{rsE[31]}}, rsE} * {{32{rtE[31]}}, rtE};
        prod_u      = {32'd0, rsE} * {32'd0, rtE};

        // Divisor forced to 1 on zero so the divider never sees /0; the
        // zero-divisor result is substituted below.
        rt_safe     = (rtE == 32'd0) ? 32'd1 : rtE;
        q_u         = rsE / rt_safe;
        r_u         = rsE % rt_safe;

        // Signed divide on magnitudes. 0x8000_0000 / -1 falls out naturally:
        // magnitude quotient 0x8000_0000, negated stays 0x8000_0000, rem 0.
        mag_rs      = rsE[31] ? (32'd0 - rsE) : rsE;
        mag_rt      = rtE[31] ? (32'd0 - rtE) : rtE;
        mag_rt_safe = (mag_rt == 32'd0) ? 32'd1 : mag_rt;
        q_mag       = mag_rs / mag_rt_safe;
        r_mag       = mag_rs % mag_rt_safe;
        q_s         = (rsE[31] ^ rtE[31]) ? (32'd0 - q_mag) : q_mag;
        r_s         = rsE[31] ? (32'd0 - r_mag) : r_mag;

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (hiloOpE)
            3'd1: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            3'd2: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            3'd3: begin res_hi = r_s;           res_lo = q_s;          end
            3'd4: begin res_hi = r_u;           res_lo = q_u;          end
            default: begin res_hi = 32'd0;      res_lo = 32'd0;        end
        endcase
        if (is_div && (rtE == 32'd0)) begin
            res_hi = rsE;
            res_lo = 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_BUSY;
                    cnt_nxt   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            S_BUSY: begin
                cnt_nxt = cnt - CW'(1);
                // Last busy cycle: commit as the counter goes 1 -> 0.
                if (cnt == CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
            // Commit only happens while busy, move-to only while idle, so
            // the two never contend for HI/LO.
            if (commit) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (!busy) begin
                if (hiloWriteE == 2'b01) hi <= rsE;
                if (hiloWriteE == 2'b10) lo <= rsE;
            end
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_ctrl
//   Directed-vector bench for md_ctrl with hand-computed expected HI/LO values.
// -----------------------------------------------------------------------------
module tb_md_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  hiloOpE;
    logic [1:0]  hiloWriteE;
    logic [31:0] rsE, rtE;
    logic        mdUseD;
    logic        start, busy, stallD;
    logic [31:0] mdOutE, hi, lo;

    always #5 clk = ~clk;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hiloOpE    (hiloOpE),
        .hiloWriteE (hiloWriteE),
        .rsE        (rsE),
        .rtE        (rtE),
        .mdUseD     (mdUseD),
        .start      (start),
        .busy       (busy),
        .stallD     (stallD),
        .mdOutE     (mdOutE),
        .hi         (hi),
        .lo         (lo)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cur_hi, cur_lo;   // model of committed HI/LO

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Launch op at cycle T with mdUseD held, check the busy/stall window,
    // the commit at T+n+1, and mfhi/mflo reads at T+n+2. With intrude set,
    // an illegal mult + mthi is forced into EX on busy cycle 2 and must be
    // ignored.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] eh,
                          input logic [31:0] el, input bit intrude);
        hiloOpE = op; hiloWriteE = 2'b00; rsE = a; rtE = b; mdUseD = 1'b1;
        #1;
        chk_val({name, " start"}, 32'(start), 32'd1);
        chk_val({name, " stall_t"}, 32'(stallD), 32'd1);
        tick();
        for (int i = 1; i <= n; i++) begin
            if (intrude && i == 2) begin
                hiloOpE = 3'd1; hiloWriteE = 2'b01; rsE = 32'h5555_5555;
            end else begin
                hiloOpE = 3'd0; hiloWriteE = 2'b00; rsE = 32'd0; rtE = 32'd0;
            end
            #1;
            chk_val({name, " busy"}, 32'(busy), 32'd1);
            chk_val({name, " stall"}, 32'(stallD), 32'd1);
            chk_val({name, " hi_hold"}, hi, cur_hi);
            chk_val({name, " lo_hold"}, lo, cur_lo);
            if (intrude && i == 2)
                chk_val({name, " no_start_busy"}, 32'(start), 32'd0);
            tick();
        end
        hiloOpE = 3'd0; hiloWriteE = 2'b00;
        #1;
        chk_val({name, " busy_clr"}, 32'(busy), 32'd0);
        chk_val({name, " stall_clr"}, 32'(stallD), 32'd0);
        chk_val({name, " hi"}, hi, eh);
        chk_val({name, " lo"}, lo, el);
        cur_hi = eh;
        cur_lo = el;
        mdUseD = 1'b0;
        tick();
        hiloOpE = 3'd5;
        #1 chk_val({name, " mfhi"}, mdOutE, eh);
        hiloOpE = 3'd6;
        #1 chk_val({name, " mflo"}, mdOutE, el);
        hiloOpE = 3'd0;
        #1 chk_val({name, " mdout_none"}, mdOutE, 32'd0);
        tick();
    endtask

    // mthi (wr=01) or mtlo (wr=10), then read both registers back.
    task automatic move_to(input string name, input logic [1:0] wr, input logic [31:0] v);
        hiloWriteE = wr; rsE = v;
        tick();
        hiloWriteE = 2'b00; rsE = 32'd0;
        if (wr == 2'b01) cur_hi = v;
        else             cur_lo = v;
        #1;
        chk_val({name, " hi"}, hi, cur_hi);
        chk_val({name, " lo"}, lo, cur_lo);
        hiloOpE = 3'd5;
        #1 chk_val({name, " mfhi"}, mdOutE, cur_hi);
        hiloOpE = 3'd6;
        #1 chk_val({name, " mflo"}, mdOutE, cur_lo);
        hiloOpE = 3'd0;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; hiloOpE = 3'd0; hiloWriteE = 2'b00;
        rsE = 32'd0; rtE = 32'd0; mdUseD = 1'b0;
        cur_hi = 32'd0; cur_lo = 32'd0;
        tick();
        tick();
        chk_val("rst busy", 32'(busy), 32'd0);
        chk_val("rst hi", hi, 32'd0);
        chk_val("rst lo", lo, 32'd0);
        chk_val("rst start", 32'(start), 32'd0);
        chk_val("rst stall", 32'(stallD), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reserved op / reserved move-to act as bubbles.
        hiloOpE = 3'd7; hiloWriteE = 2'b11; rsE = 32'h1111_1111; mdUseD = 1'b1;
        #1;
        chk_val("rsvd start", 32'(start), 32'd0);
        chk_val("rsvd stall", 32'(stallD), 32'd0);
        tick();
        hiloOpE = 3'd0; hiloWriteE = 2'b00; mdUseD = 1'b0;
        #1;
        chk_val("rsvd hi", hi, 32'd0);
        chk_val("rsvd lo", lo, 32'd0);
        chk_val("rsvd busy", 32'(busy), 32'd0);

        run_op("mult_neg",  3'd1, 32'hFFFF_FFFD, 32'd5,        5,  32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("divu_7_2",  3'd4, 32'd7,         32'd2,        10, 32'd1,         32'd3,         1'b0);
        run_op("div_m7_2",  3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_7_m2",  3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'd1,        32'hFFFF_FFFD, 1'b0);
        run_op("div_by0",   3'd3, 32'h0000_1234, 32'd0,        10, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_by0",  3'd4, 32'hFFFF_FFFF, 32'd0,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,        32'h8000_0000, 1'b0);
        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("divu_intr", 3'd4, 32'd100,       32'd7,        10, 32'd2,         32'd14,        1'b1);

        move_to("mthi", 2'b01, 32'hDEAD_BEEF);
        move_to("mtlo", 2'b10, 32'h0BAD_F00D);

        // Reset in busy cycle 3 of a divu: aborted, no late commit.
        hiloOpE = 3'd4; rsE = 32'd100; rtE = 32'd7;
        #1 chk_val("abort start", 32'(start), 32'd1);
        tick();
        hiloOpE = 3'd0; rsE = 32'd0; rtE = 32'd0;
        tick();
        tick();
        rst_n = 1'b0;
        #1 chk_val("abort busy3", 32'(busy), 32'd1);
        tick();
        rst_n = 1'b1;
        #1;
        chk_val("abort busy", 32'(busy), 32'd0);
        chk_val("abort hi", hi, 32'd0);
        chk_val("abort lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk_val("abort late busy", 32'(busy), 32'd0);
        chk_val("abort late hi", hi, 32'd0);
        chk_val("abort late lo", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the P6 pipeline: it owns the HI/LO registers and the busy counter for the shared multi-cycle multiply/divide resource. It launches operations from the ID/EX stage's `hiloOp`/`hiloWrite` fields and commits results to HI/LO after a fixed latency. It also issues the decode-stage stall request that keeps later HI/LO instructions out of EX while the unit is occupied. It sits beside the ALU in EX; its read data feeds the EX result mux.

## Interface

**Parameters**
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

**Ports**
- `clk` input 1: pipeline clock; all state changes on rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `hiloOpE` input 3: EX-stage op. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 reserved (treated as none).
- `hiloWriteE` input 2: EX-stage move-to. 00 none, 01 mthi, 10 mtlo, 11 reserved (none).
- `rsE` input 32: forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- `rtE` input 32: forwarded rt operand.
- `mdUseD` input 1: ID-stage instruction is any HI/LO op (hiloOpD≠0 or hiloWriteD≠0).
- `start` output 1: combinational; op 1–4 accepted this cycle.
- `busy` output 1: registered; unit computing.
- `stallD` output 1: combinational; `mdUseD && (start || busy)`.
- `mdOutE` output 32: combinational. HI when hiloOpE=5, LO when 6, else 0.
- `hi` output 32: committed HI register.
- `lo` output 32: committed LO register.

## Operation

**Reset**
- When `rst_n`=0 at a clock edge, clear the following to 0: `hi`, `lo`, the counter, `busy`, pending HI/LO, and the op latch.
- Reset mid-operation aborts the operation; no late commit occurs.

**Start**
- `start = (hiloOpE ∈ {1..4}) && !busy`.
- On the `start` edge:
  - Compute the full result into pending registers.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - Set `busy`.

**Arithmetic**
- mult: signed 32×32→64, HI=[63:32], LO=[31:0].
- multu: unsigned 32×32→64, same split.
- div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
- divu: unsigned.
- Divide by zero (rt=0): HI=rs, LO=32'hFFFF_FFFF, for both signed and unsigned.
- Signed overflow 32'h8000_0000 / −1: LO=32'h8000_0000, HI=0.

**Counter and commit**
- The counter decrements each cycle while `busy`.
- At the edge where the counter goes 1→0: HI/LO take the pending values and `busy` clears.

**Move-to and move-from**
- mthi/mtlo write `rsE` into HI/LO at the edge, only when `!busy`.
- mfhi/mflo read the committed registers through `mdOutE`.

**Ops arriving while busy**
- `stallD` guarantees no op 1–6 and no move-to reaches EX while busy.
- If one does arrive anyway, it is ignored (no start, no write). The bench flags this as a protocol violation.

## Timing

**Latency**
- Op in EX at cycle T, so `start`=1 at T.
- `busy`=1 for cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES).
- New HI/LO visible on `hi`/`lo` from T+N+1.
- `busy`=0 at T+N+1, and a new start is accepted at T+N+1.

**Stall**
- `stallD`=1 during T … T+N whenever `mdUseD`=1.
- An mfhi held in ID enters EX at T+N+2 and reads the new value.

**Move-to**
- mthi/mtlo in EX at cycle T: new value on `hi`/`lo` at T+1.
- An mfhi/mflo in EX at T+1 sees the new value.

**Bubbles**
- A cleared ID/EX (hiloOpE=0, hiloWriteE=0) has no effect on the unit.
- An in-flight operation keeps counting through bubbles and stalls.

## Test plan

- **Signed multiply:** mult rs=32'hFFFF_FFFD (−3), rt=5.
  - `busy` high for exactly 5 cycles.
  - At T+6: hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
- **Unsigned divide:** divu rs=7, rt=2.
  - `busy` for 10 cycles.
  - At T+11: lo=3, hi=1.
  - div rs=−7, rt=2 gives lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- **Divide corner cases:**
  - div rs=32'h1234, rt=0 → hi=32'h1234, lo=32'hFFFF_FFFF.
  - div 32'h8000_0000 / 32'hFFFF_FFFF → lo=32'h8000_0000, hi=0.
- **Stall window:** mult at T with `mdUseD`=1 held.
  - `stallD`=1 exactly for T…T+5 and 0 at T+6.
  - mflo entering EX at T+7 gives `mdOutE`=product LO.
- **Move-to / move-from:** mthi rs=32'hDEAD_BEEF.
  - hi=32'hDEAD_BEEF next cycle.
  - mfhi in EX the following cycle gives `mdOutE`=32'hDEAD_BEEF.
  - lo is unchanged.
- **Reset mid-operation:** divu started, `rst_n`=0 at busy cycle 3.
  - Next cycle: busy=0, hi=lo=0.
  - After `rst_n` returns high, no commit occurs over the following 10 cycles.
